mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_if.sv | 21 ++
 rtl/mdu.sv | 116 +++++++++++
 tb/tb_mdu.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared project definitions: MDU op encodings plus the datapath selector
// encodings used by the rest of the CPU (ALU, A3, WD muxes).
package mdu_pkg;

    // MDU operation codes; 6 and 7 are illegal and ignored by the unit.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI = 3'd3
    } alu_sel_e;

    typedef enum logic [1:0] {
        A3_RT = 2'd0, A3_RD = 2'd1, A3_RA = 2'd2
    } a3_sel_e;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC8 = 2'd2, WD_MDU = 2'd3
    } wd_sel_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_MTLO;
    endfunction

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// MDU request/result bundle. The flush input exists only when MDU_FLUSH_EN
// is defined.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef MDU_FLUSH_EN
    logic        flush;

    modport master (output start, op, A, B, flush, input busy, done, HI, LO);
    modport slave  (input start, op, A, B, flush, output busy, done, HI, LO);
`else
    modport master (output start, op, A, B, input busy, done, HI, LO);
    modport slave  (input start, op, A, B, output busy, done, HI, LO);
`endif
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO. The result is computed
// combinationally at the accept edge and parked in a shadow register; a
// down-counter models the multi-cycle latency before HI/LO commit.
// Optional macro MDU_FLUSH_EN adds a flush input that kills the in-flight op.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);

    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_shadow;

    logic        w_flush;
    logic        w_accept;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_res;

`ifdef MDU_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_accept = bus.start && !r_busy && op_legal(bus.op) && !w_flush;

    assign w_prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign w_prod_u = {32'b0, bus.A} * {32'b0, bus.B};

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    assign w_a_neg = (bus.op == OP_DIV) && bus.A[31];
    assign w_b_neg = (bus.op == OP_DIV) && bus.B[31];
    assign w_a_mag = w_a_neg ? (~bus.A + 32'd1) : bus.A;
    assign w_b_mag = w_b_neg ? (~bus.B + 32'd1) : bus.B;
    assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_q     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // Select the 64-bit {HI,LO} result for the requested op.
    always_comb begin
        w_res = '0;
        case (bus.op)
            OP_MULT:  w_res = w_prod_s;
            OP_MULTU: w_res = w_prod_u;
            OP_DIV, OP_DIVU: begin
                if (bus.B == 32'd0) w_res = {bus.A, 32'hFFFF_FFFF};
                else                w_res = {w_r, w_q};
            end
            default:  w_res = '0;
        endcase
    end

    // Accept, count down, commit; flush beats everything but reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_shadow <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_flush) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (r_busy) begin
                if (r_cnt == 4'd1) begin
                    r_hi   <= r_shadow[63:32];
                    r_lo   <= r_shadow[31:0];
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end else if (w_accept) begin
                case (bus.op)
                    OP_MTHI: r_hi <= bus.A;
                    OP_MTLO: r_lo <= bus.A;
                    default: begin
                        r_shadow <= w_res;
                        r_busy   <= 1'b1;
                        r_cnt    <= op_is_mul(bus.op) ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
                    end
                endcase
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: a transaction-level reference model (due-cycle bookkeeping,
// plain SV arithmetic) compared every cycle, plus directed literal checks.
module tb_mdu;

    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mdu_if bus();

    mdu #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference {HI,LO} from the arithmetic definition of each op.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint p;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            3'd1: return {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    logic m_flush_in;
`ifdef MDU_FLUSH_EN
    assign m_flush_in = bus.flush;
`else
    assign m_flush_in = 1'b0;
`endif

    // Model: an accepted multi-cycle op is due N edges after acceptance.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_pend = 1'b0, m_done = 1'b0;
    logic [63:0] m_res = '0;
    longint      cyc = 0, m_due = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_pend = 1'b0; m_done = 1'b0;
        end else begin
            cyc++;
            m_done = 1'b0;
            if (m_flush_in) begin
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (cyc == m_due) begin
                    {m_hi, m_lo} = m_res;
                    m_pend = 1'b0;
                    m_done = 1'b1;
                end
            end else if (bus.start && bus.op <= 3'd5) begin
                if (bus.op == 3'd4)      m_hi = bus.A;
                else if (bus.op == 3'd5) m_lo = bus.A;
                else begin
                    m_res  = ref_op(bus.op, bus.A, bus.B);
                    m_pend = 1'b1;
                    m_due  = cyc + ((bus.op < 3'd2) ? MULN : DIVN);
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("busy", {63'b0, bus.busy}, {63'b0, m_pend});
        check("done", {63'b0, bus.done}, {63'b0, m_done});
        check("HI", {32'b0, bus.HI}, {32'b0, m_hi});
        check("LO", {32'b0, bus.LO}, {32'b0, m_lo});
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) check("busy_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int en);
        int n;
        drive(op, a, b);
        wait_idle(n);
        check({name, "_cycles"}, 64'(n), 64'(en));
        check({name, "_done"}, {63'b0, bus.done}, 64'd1);
        check({name, "_HI"}, {32'b0, bus.HI}, {32'b0, ehi});
        check({name, "_LO"}, {32'b0, bus.LO}, {32'b0, elo});
        @(negedge clk);
        check({name, "_done_pulse"}, {63'b0, bus.done}, 64'd0);
    endtask

    initial begin
        int n, d;
        bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
`ifdef MDU_FLUSH_EN
        bus.flush = 1'b0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        check("rst_HI", {32'b0, bus.HI}, 64'd0);
        check("rst_LO", {32'b0, bus.LO}, 64'd0);
        repeat (2) @(negedge clk);

        // First request on the first edge after release.
        rst_n = 1'b1;
        bus.start = 1'b1; bus.op = 3'd5; bus.A = 32'hABCD;
        @(negedge clk);
        bus.start = 1'b0;
        check("first_MTLO", {32'b0, bus.LO}, 64'h0000_ABCD);

        run_op("MULT",  3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULN);
        run_op("MULTU", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MULN);
        run_op("DIV",   3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIVN);
        run_op("DIVU0", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, DIVN);
        run_op("DIV0",  3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DIVN);
        run_op("DIVOV", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIVN);
        run_op("DIVNB", 3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, DIVN);
        run_op("DIVU",  3'd3, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, DIVN);

        // MTHI while busy is dropped; after done it lands.
        drive(3'd2, 32'd20, 32'd3);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(n);
        check("busy_MTHI_HI", {32'b0, bus.HI}, 64'd2);
        check("busy_MTHI_LO", {32'b0, bus.LO}, 64'd6);
        bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_MTHI_HI", {32'b0, bus.HI}, 64'h1234);
        check("idle_MTHI_busy", {63'b0, bus.busy}, 64'd0);

        // Request held through the falling-busy edge is taken one edge later.
        drive(3'd1, 32'd3, 32'd4);
        bus.start = 1'b1; bus.op = 3'd5; bus.A = 32'h55;
        wait_idle(n);
        check("held_commit_LO", {32'b0, bus.LO}, 64'd12);
        @(negedge clk);
        bus.start = 1'b0;
        check("held_accept_LO", {32'b0, bus.LO}, 64'h55);

        // Illegal op codes leave everything alone.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd6; bus.A = 32'hDEAD; bus.B = 32'd1;
        @(negedge clk);
        bus.op = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        check("illegal_busy", {63'b0, bus.busy}, 64'd0);
        check("illegal_LO", {32'b0, bus.LO}, 64'h55);

        // Reset three cycles into a MULT.
        drive(3'd0, 32'd5, 32'd6);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'b0, bus.busy}, 64'd0);
        check("midrst_HI", {32'b0, bus.HI}, 64'd0);
        check("midrst_LO", {32'b0, bus.LO}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) d++;
        end
        check("midrst_no_done", 64'(d), 64'd0);

`ifdef MDU_FLUSH_EN
        drive(3'd4, 32'h1111, 32'd0);
        drive(3'd5, 32'h2222, 32'd0);
        drive(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {63'b0, bus.busy}, 64'd0);
        d = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) d++;
        end
        check("flush_no_done", 64'(d), 64'd0);
        check("flush_HI", {32'b0, bus.HI}, 64'h1111);
        check("flush_LO", {32'b0, bus.LO}, 64'h2222);
`endif

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
